// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/arith ops, iterative shift-add MUL,
// result and flags held until the consumer accepts them.
module alu_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] Control,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  zero,
  output logic                  carry,
  output logic                  overflow,
  output logic                  illegal
);

  localparam int SW  = $clog2(DATA_WIDTH);
  localparam int CW  = $clog2(DATA_WIDTH + 1);
  localparam int MSB = DATA_WIDTH - 1;

  localparam logic [CTRL_WIDTH-1:0] OP_ADD = CTRL_WIDTH'(0);
  localparam logic [CTRL_WIDTH-1:0] OP_SUB = CTRL_WIDTH'(1);
  localparam logic [CTRL_WIDTH-1:0] OP_MUL = CTRL_WIDTH'(2);
  localparam logic [CTRL_WIDTH-1:0] OP_AND = CTRL_WIDTH'(3);
  localparam logic [CTRL_WIDTH-1:0] OP_OR  = CTRL_WIDTH'(4);
  localparam logic [CTRL_WIDTH-1:0] OP_XOR = CTRL_WIDTH'(5);
  localparam logic [CTRL_WIDTH-1:0] OP_SLT = CTRL_WIDTH'(6);
  localparam logic [CTRL_WIDTH-1:0] OP_SLL = CTRL_WIDTH'(7);
  localparam logic [CTRL_WIDTH-1:0] OP_SRL = CTRL_WIDTH'(8);
  localparam logic [CTRL_WIDTH-1:0] OP_SRA = CTRL_WIDTH'(9);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0]   alu_res;
  logic                    alu_carry;
  logic                    alu_ovf;
  logic                    alu_illegal;
  logic                    is_mul;
  logic [DATA_WIDTH:0]     sum;
  logic [DATA_WIDTH:0]     diff;
  logic [SW-1:0]           shamt;

  logic [2*DATA_WIDTH-1:0] acc;
  logic [2*DATA_WIDTH-1:0] acc_next;
  logic [2*DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0]   mplier;
  logic [CW-1:0]           count;
  logic                    accept;
  logic                    mul_last;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;
  assign mul_last  = (count == CW'(DATA_WIDTH - 1));
  assign shamt     = B[SW-1:0];
  assign acc_next  = acc + (mplier[0] ? mcand : '0);

  // Single-cycle datapath evaluated straight off the operand inputs at acceptance
  always_comb begin
    alu_res     = '0;
    alu_carry   = 1'b0;
    alu_ovf     = 1'b0;
    alu_illegal = 1'b0;
    is_mul      = 1'b0;
    sum         = {1'b0, A} + {1'b0, B};
    diff        = {1'b0, A} - {1'b0, B};
    case (Control)
      OP_ADD: begin
        alu_res   = sum[DATA_WIDTH-1:0];
        alu_carry = sum[DATA_WIDTH];
        alu_ovf   = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
      end
      OP_SUB: begin
        alu_res   = diff[DATA_WIDTH-1:0];
        alu_carry = ~diff[DATA_WIDTH];
        alu_ovf   = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
      end
      OP_MUL: is_mul  = 1'b1;
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_XOR: alu_res = A ^ B;
      OP_SLT: alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLL: alu_res = A << shamt;
      OP_SRL: alu_res = A >> shamt;
      OP_SRA: alu_res = $signed(A) >>> shamt;
      default: alu_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = is_mul ? S_MUL : S_DONE;
      S_MUL:  if (mul_last) state_next = S_DONE;
      S_DONE: if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Result/flag registers and the shift-add engine; the last MUL iteration
  // registers the sum it produces so latency stays exactly DATA_WIDTH cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Result   <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      count    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              acc    <= '0;
              mcand  <= {{DATA_WIDTH{1'b0}}, A};
              mplier <= B;
              count  <= '0;
            end else begin
              Result   <= alu_res;
              zero     <= (alu_res == '0);
              carry    <= alu_carry;
              overflow <= alu_ovf;
              illegal  <= alu_illegal;
            end
          end
        end
        S_MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          if (mul_last) begin
            Result   <= acc_next[DATA_WIDTH-1:0];
            zero     <= (acc_next[DATA_WIDTH-1:0] == '0);
            carry    <= 1'b0;
            overflow <= |acc_next[2*DATA_WIDTH-1:DATA_WIDTH];
            illegal  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at DATA_WIDTH=8 with hand-computed vectors.
module tb_alu_seq;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] control;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       zero;
  logic       carry;
  logic       overflow;
  logic       illegal;

  int assertCount = 0;
  int failCount   = 0;

  alu_seq #(.DATA_WIDTH(8), .CTRL_WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Control   (control),
    .A         (a),
    .B         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (result),
    .zero      (zero),
    .carry     (carry),
    .overflow  (overflow),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation for exactly one accepting edge
  task automatic applyStimulus(input logic [3:0] ctrl, input logic [7:0] opA, input logic [7:0] opB);
    checkOutput("ready_before_accept", in_ready, 1);
    control  = ctrl;
    a        = opA;
    b        = opB;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    control  = 4'h0;
    a        = 8'h5A;
    b        = 8'hC3;
  endtask

  task automatic checkFlags(input string tag, input logic [7:0] r, input logic z, input logic c,
                            input logic o, input logic il);
    checkOutput({tag, "_result"}, result, r);
    checkOutput({tag, "_zero"}, zero, z);
    checkOutput({tag, "_carry"}, carry, c);
    checkOutput({tag, "_overflow"}, overflow, o);
    checkOutput({tag, "_illegal"}, illegal, il);
  endtask

  task automatic drainResult(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, out_valid, 0);
    checkOutput({tag, "_ready_back"}, in_ready, 1);
  endtask

  task automatic runSimple(input string tag, input logic [3:0] ctrl, input logic [7:0] opA,
                           input logic [7:0] opB, input logic [7:0] r, input logic z,
                           input logic c, input logic o, input logic il);
    applyStimulus(ctrl, opA, opB);
    checkOutput({tag, "_latency1"}, out_valid, 1);
    checkFlags(tag, r, z, c, o, il);
    drainResult(tag);
  endtask

  task automatic runMul(input string tag, input logic [7:0] opA, input logic [7:0] opB,
                        input logic [7:0] r, input logic z, input logic o);
    int cycles;
    int readyLeak;
    applyStimulus(4'd2, opA, opB);
    cycles    = 0;
    readyLeak = 0;
    while (!out_valid && cycles < 50) begin
      if (in_ready) readyLeak++;
      tick();
      cycles++;
    end
    checkOutput({tag, "_latency"}, cycles, 8);
    checkOutput({tag, "_ready_low"}, readyLeak, 0);
    checkFlags(tag, r, z, 1'b0, o, 1'b0);
    drainResult(tag);
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    control   = 4'h0;
    a         = 8'h00;
    b         = 8'h00;
    tick();
    tick();
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkFlags("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();

    runSimple("add_wrap", 4'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    runSimple("add_sovf", 4'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
    runSimple("sub_ovf",  4'd1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1, 1'b0);
    runSimple("sub_borrow", 4'd1, 8'h01, 8'h02, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    runSimple("slt_neg",  4'd6, 8'hFE, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    runSimple("slt_pos",  4'd6, 8'h01, 8'hFE, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    runSimple("and",      4'd3, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    runSimple("or",       4'd4, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b0);
    runSimple("sll_mask", 4'd7, 8'h81, 8'h0B, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0);
    runSimple("illegal",  4'hF, 8'h12, 8'h34, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    runSimple("sra",      4'd9, 8'h90, 8'h02, 8'hE4, 1'b0, 1'b0, 1'b0, 1'b0);
    runSimple("srl",      4'd8, 8'h90, 8'h02, 8'h24, 1'b0, 1'b0, 1'b0, 1'b0);

    runMul("mul_ovf", 8'h10, 8'h11, 8'h10, 1'b0, 1'b1);
    runMul("mul_small", 8'h03, 8'h05, 8'h0F, 1'b0, 1'b0);
    runMul("mul_zero", 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0);

    // Backpressure with a competing request that must be ignored
    applyStimulus(4'd5, 8'hAA, 8'h0F);
    control  = 4'd0;
    a        = 8'h01;
    b        = 8'h01;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_result", result, 8'hA5);
      checkOutput("bp_valid", out_valid, 1);
      checkOutput("bp_in_ready", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    drainResult("bp");
    tick();
    checkOutput("bp_no_ghost", out_valid, 0);

    // Reset in the middle of a multiply
    applyStimulus(4'd2, 8'h07, 8'h09);
    tick();
    tick();
    tick();
    reset = 1'b0;
    #1;
    checkOutput("midreset_out_valid", out_valid, 0);
    checkOutput("midreset_in_ready", in_ready, 1);
    checkOutput("midreset_result", result, 8'h00);
    tick();
    reset = 1'b1;
    tick();
    checkOutput("postreset_idle", out_valid, 0);
    runSimple("post_reset_add", 4'd0, 8'h02, 8'h03, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
